// File: rtl/synth_audio_pkg.sv
// Shared constants and helpers for the synthesizer audio output path.
// Imported by the I2S transmitter and its clock generator.
package synth_audio_pkg;

  localparam int CLK_HZ       = 100_000_000;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_SLOT_W   = 32;
  localparam int DEF_MCLK_DIV = 4;
  localparam int DEF_SCK_DIV  = 32;

  typedef enum logic {
    MODE_I2S = 1'b0,
    MODE_LJ  = 1'b1
  } mode_e;

  function automatic int frame_clks(
    input int slot_w,
    input int sck_div
  );
    return 2 * slot_w * sck_div;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Bit and master clock divider for the I2S transmitter.
// sck_fall flags the clk edge on which sck goes low.
module i2s_clkgen
  import synth_audio_pkg::*;
#(
  parameter int MCLK_DIV = DEF_MCLK_DIV,
  parameter int SCK_DIV  = DEF_SCK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic mclk,
  output logic sck,
  output logic sck_fall
);

  localparam int CW = $clog2(SCK_DIV);
  localparam int MH = MCLK_DIV / 2;
  localparam logic [CW-1:0] LAST = CW'(SCK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(SCK_DIV / 2 - 1);

  logic [CW-1:0] cnt;
  logic          sck_rise;
  logic          mclk_tgl;

  // mclk phase stays locked to sck since SCK_DIV is a multiple of MCLK_DIV
  assign sck_rise = (cnt == HALF);
  assign sck_fall = (cnt == LAST);
  assign mclk_tgl = ((int'(cnt) % MH) == (MH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      mclk <= 1'b0;
      sck  <= 1'b0;
    end else begin
      cnt <= sck_fall ? '0 : cnt + CW'(1);
      if (mclk_tgl) mclk <= ~mclk;
      if (sck_rise) sck <= 1'b1;
      else if (sck_fall) sck <= 1'b0;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// Stereo I2S / left-justified serialiser with a one-entry
// sample holding register and underrun reporting.
module i2s_tx
  import synth_audio_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SLOT_W   = DEF_SLOT_W,
  parameter int MCLK_DIV = DEF_MCLK_DIV,
  parameter int SCK_DIV  = DEF_SCK_DIV,
  parameter int LJ       = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] l_data,
  input  logic [DATA_W-1:0] r_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mclk,
  output logic              lrck,
  output logic              sck,
  output logic              sdout,
  output logic              frame_start,
  output logic              underrun
);

  localparam int FW = 2 * SLOT_W;
  localparam int BW = $clog2(FW);
  localparam logic [BW-1:0] BLAST = BW'(FW - 1);
  localparam logic [BW-1:0] RSLOT = BW'(SLOT_W);
  localparam bit IS_LJ = (LJ == int'(MODE_LJ));

  logic              sck_fall;
  logic [BW-1:0]     bcnt;
  logic [BW-1:0]     bcnt_n;
  logic [FW-1:0]     shift;
  logic [FW-1:0]     shift_n;
  logic [FW-1:0]     frame;
  logic [DATA_W-1:0] l_h;
  logic [DATA_W-1:0] r_h;
  logic              hold_full;
  logic              hold_n;
  logic              accept;
  logic              load;

  i2s_clkgen #(
    .MCLK_DIV(MCLK_DIV),
    .SCK_DIV (SCK_DIV)
  ) u_clkgen (
    .clk     (clk),
    .rst     (rst),
    .mclk    (mclk),
    .sck     (sck),
    .sck_fall(sck_fall)
  );

  assign accept = in_valid && in_ready;
  assign load   = sck_fall && (bcnt == BLAST);

  always_comb begin
    frame = '0;
    frame[FW-1 -: DATA_W]     = l_h;
    frame[SLOT_W-1 -: DATA_W] = r_h;
  end

  always_comb begin
    bcnt_n  = load ? '0 : bcnt + BW'(1);
    shift_n = shift << 1;
    if (load) shift_n = hold_full ? frame : '0;
  end

  // the load uses the pre-cycle holding state; a same-cycle accept waits
  always_comb begin
    hold_n = hold_full;
    if (load) hold_n = 1'b0;
    if (accept) hold_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt        <= BLAST;
      shift       <= '0;
      l_h         <= '0;
      r_h         <= '0;
      hold_full   <= 1'b0;
      in_ready    <= 1'b0;
      lrck        <= 1'b0;
      sdout       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= load;
      underrun    <= load && !hold_full;
      hold_full   <= hold_n;
      in_ready    <= !hold_n;
      if (accept) begin
        l_h <= l_data;
        r_h <= r_data;
      end
      if (sck_fall) begin
        bcnt  <= bcnt_n;
        shift <= shift_n;
        lrck  <= (bcnt_n >= RSLOT);
        // in I2S mode sdout itself is the one-bit delay stage
        sdout <= IS_LJ ? shift_n[FW-1] : shift[FW-1];
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: runs I2S and LJ instances side by side
// on the same sample stream and checks timing, data and handshake.
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] l_data = '0;
  logic [15:0] r_data = '0;
  logic        in_valid = 1'b0;

  logic ir0, mk0, lr0, sk0, sd0, fs0, ur0;
  logic ir1, mk1, lr1, sk1, sd1, fs1, ur1;

  int tests = 0;
  int fails = 0;
  int accepts = 0;
  logic [31:0] q[$];

  typedef struct {
    int          push_at;
    int          n;
    logic [15:0] l;
    logic [15:0] r;
    logic [63:0] w;
    logic        ur;
    int          acc;
  } rec_t;

  rec_t tbl[9];

  always #5 clk = ~clk;

  i2s_tx #(.LJ(0)) u_i2s (
    .clk(clk), .rst(rst), .l_data(l_data), .r_data(r_data),
    .in_valid(in_valid), .in_ready(ir0), .mclk(mk0), .lrck(lr0),
    .sck(sk0), .sdout(sd0), .frame_start(fs0), .underrun(ur0)
  );

  i2s_tx #(.LJ(1)) u_lj (
    .clk(clk), .rst(rst), .l_data(l_data), .r_data(r_data),
    .in_valid(in_valid), .in_ready(ir1), .mclk(mk1), .lrck(lr1),
    .sck(sk1), .sdout(sd1), .frame_start(fs1), .underrun(ur1)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic acc;
    acc = in_valid && ir1;
    @(posedge clk);
    #1;
    if (acc) begin
      accepts++;
      void'(q.pop_front());
    end
    if (q.size() > 0) begin
      in_valid = 1'b1;
      l_data   = q[0][31:16];
      r_data   = q[0][15:0];
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    q.push_back({l, r});
    if (!in_valid) begin
      in_valid = 1'b1;
      l_data   = l;
      r_data   = r;
    end
  endtask

  task automatic chk_reset(input string name);
    chk(name, 64'({ir1, mk1, lr1, sk1, sd1, fs1, ur1,
                   ir0, mk0, lr0, sk0, sd0, fs0, ur0}), 64'h0);
  endtask

  task automatic post_reset(input bit do_push, input logic exp_ur);
    tick();
    chk("rdy_t1", 64'(ir1), 64'h1);
    chk("mclk_t1", 64'(mk1), 64'h0);
    if (do_push) push(16'hA5F0, 16'h0F0F);
    tick();
    chk("mclk_t2", 64'(mk1), 64'h1);
    for (int t = 3; t <= 32; t++) begin
      tick();
      if (t == 15) chk("sck_t15", 64'(sk1), 64'h0);
      if (t == 16) chk("sck_t16", 64'(sk1), 64'h1);
      if (t == 31) chk("fs_t31", 64'(fs1), 64'h0);
    end
    chk("fs_t32", 64'(fs1), 64'h1);
    chk("sck_t32", 64'(sk1), 64'h0);
    chk("ur_t32", 64'(ur1), 64'(exp_ur));
  endtask

  task automatic wait_rise(output bit ok, inout int el);
    logic prev;
    ok = 1'b0;
    for (int g = 0; g < 64 && !ok; g++) begin
      prev = sk1;
      tick();
      el++;
      if (sk1 && !prev) ok = 1'b1;
    end
    if (!ok) chk("rise_timeout", 64'h0, 64'h1);
  endtask

  task automatic capture(input rec_t v, input int idx);
    logic [63:0] c0, c1, lr;
    int el, a0;
    bit ok;
    el = 0;
    a0 = accepts;
    c0 = '0; c1 = '0; lr = '0;
    chk($sformatf("fs_%0d", idx), 64'(fs1), 64'h1);
    chk($sformatf("ur_%0d", idx), 64'({ur0, ur1}), 64'({v.ur, v.ur}));
    for (int i = 0; i < 64; i++) begin
      wait_rise(ok, el);
      if (!ok) break;
      c0[63-i] = sd0;
      c1[63-i] = sd1;
      lr[63-i] = lr1;
      if (i == v.push_at)
        for (int k = 0; k < v.n; k++)
          push(v.l + 16'(k), v.r + 16'(k));
    end
    ok = 1'b0;
    for (int g = 0; g < 64 && !ok; g++) begin
      tick();
      el++;
      if (fs1) ok = 1'b1;
    end
    chk($sformatf("len_%0d", idx), 64'(el), 64'd2048);
    chk($sformatf("lj_%0d", idx), c1, v.w);
    chk($sformatf("i2s_%0d", idx), c0, {1'b0, v.w[63:1]});
    chk($sformatf("lrck_%0d", idx), lr, 64'h0000_0000_FFFF_FFFF);
    chk($sformatf("acc_%0d", idx), 64'(accepts - a0), 64'(v.acc));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t nul;
    bit ok;
    int el;
    tbl[0] = '{-1, 0, 16'h0, 16'h0, 64'hA5F0_0000_0F0F_0000, 1'b0, 0};
    tbl[1] = '{-1, 0, 16'h0, 16'h0, 64'h0, 1'b1, 0};
    tbl[2] = '{20, 1, 16'h7FFF, 16'h7FFF, 64'h0, 1'b1, 1};
    tbl[3] = '{-1, 0, 16'h0, 16'h0, 64'h7FFF_0000_7FFF_0000, 1'b0, 0};
    tbl[4] = '{-1, 0, 16'h0, 16'h0, 64'h0, 1'b1, 0};
    tbl[5] = '{0, 3, 16'h0001, 16'h0101, 64'h0, 1'b1, 1};
    tbl[6] = '{-1, 0, 16'h0, 16'h0, 64'h0001_0000_0101_0000, 1'b0, 1};
    tbl[7] = '{-1, 0, 16'h0, 16'h0, 64'h0002_0000_0102_0000, 1'b0, 1};
    tbl[8] = '{-1, 0, 16'h0, 16'h0, 64'h0003_0000_0103_0000, 1'b0, 0};
    nul = '{-1, 0, 16'h0, 16'h0, 64'h0, 1'b1, 0};

    for (int i = 0; i < 3; i++) begin
      tick();
      chk_reset("por");
    end
    rst = 1'b0;
    repeat (50) tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_reset("rst_active");
    end
    rst = 1'b0;
    post_reset(1'b1, 1'b0);

    for (int i = 0; i < 9; i++) capture(tbl[i], i);

    chk("ur_idle", 64'(ur1), 64'h1);
    push(16'h1234, 16'h5678);
    ok = 1'b0;
    for (int g = 0; g < 2100 && !ok; g++) begin
      tick();
      if (fs1) ok = 1'b1;
    end
    chk("fs_valid", 64'(ok), 64'h1);
    chk("ur_valid", 64'(ur1), 64'h0);
    el = 0;
    for (int i = 0; i < 21; i++) wait_rise(ok, el);
    push(16'hBEEF, 16'hCAFE);
    tick();
    tick();
    chk("rdy_full", 64'(ir1), 64'h0);
    rst = 1'b1;
    tick();
    chk_reset("rst_mid");
    rst = 1'b0;
    post_reset(1'b0, 1'b1);
    capture(nul, 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
